sda_axi_lite_reg_bridge: RTL and testbench

SDA_AXI_LITE_REG_BRIDGE -- requirements
Module: sda_axi_lite_reg_bridge

---
 rtl/sda_axi_lite_reg_bridge.sv | 197 +++++++++++++++++++
 tb/tb_sda_axi_lite_reg_bridge.sv | 573 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sda_axi_lite_reg_bridge.sv
// AXI4-Lite slave to single-strobe register bus bridge: one transaction in flight,
// one-entry holders per request channel, alternating write/read arbitration.
module sda_axi_lite_reg_bridge #(
    parameter int RegAddrWidth = 12,
    parameter int AxiAddrWidth = 14,
    parameter int ReadLatency  = 1
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [AxiAddrWidth-1:0] s_awaddr,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [31:0]             s_wdata,
    input  logic [3:0]              s_wstrb,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [AxiAddrWidth-1:0] s_araddr,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [31:0]             s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    regReq,
    output logic                    regWriteEn,
    output logic [RegAddrWidth-1:0] regAddr,
    output logic [31:0]             regWData,
    output logic [3:0]              regWStrb,
    input  logic [31:0]             regRData
);

    // Handshake rule on every channel: a beat transfers at a rising edge where
    // valid and ready are both high; valid holds its payload until that edge.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_aw_held;
    logic                    r_w_held;
    logic                    r_ar_held;
    logic [RegAddrWidth-1:0] r_aw_addr;
    logic [RegAddrWidth-1:0] r_ar_addr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wstrb;
    logic [3:0]              r_wait_cnt;
    logic                    r_last_rd;
    logic [31:0]             r_rdata;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_ar_hs;
    logic                    w_unused_addr_bits;

    assign s_awready = !r_aw_held && !srst;
    assign s_wready  = !r_w_held && !srst;
    assign s_arready = !r_ar_held && !srst;
    assign w_aw_hs   = s_awvalid && s_awready;
    assign w_w_hs    = s_wvalid && s_wready;
    assign w_ar_hs   = s_arvalid && s_arready;
    assign s_bresp   = 2'b00;
    assign s_rresp   = 2'b00;
    assign s_rdata   = r_rdata;

    // Byte-lane bits and address bits above the register window are dropped.
    assign w_unused_addr_bits = ^{s_awaddr, s_araddr};

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_ar_held <= 1'b0;
            r_aw_addr <= '0;
            r_ar_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_awaddr[RegAddrWidth+1:2];
            end else if (r_state == ST_WR_REQ) begin
                r_aw_held <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_wdata;
                r_wstrb  <= s_wstrb;
            end else if (r_state == ST_WR_REQ) begin
                r_w_held <= 1'b0;
            end
            if (w_ar_hs) begin
                r_ar_held <= 1'b1;
                r_ar_addr <= s_araddr[RegAddrWidth+1:2];
            end else if (r_state == ST_RD_REQ) begin
                r_ar_held <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        regReq       = 1'b0;
        regWriteEn   = 1'b0;
        regAddr      = '0;
        regWData     = '0;
        regWStrb     = '0;
        s_bvalid     = 1'b0;
        s_rvalid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A write wins unless a read is also waiting and the last grant was a write.
                if (r_aw_held && r_w_held && (!r_ar_held || r_last_rd)) begin
                    w_next_state = ST_WR_REQ;
                end else if (r_ar_held) begin
                    w_next_state = ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                regReq       = 1'b1;
                regWriteEn   = 1'b1;
                regAddr      = r_aw_addr;
                regWData     = r_wdata;
                regWStrb     = r_wstrb;
                w_next_state = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                regReq       = 1'b1;
                regAddr      = r_ar_addr;
                w_next_state = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (r_wait_cnt == 4'd1) begin
                    w_next_state = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                s_rvalid = 1'b1;
                if (s_rready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // The counter reaches 1 in the cycle ReadLatency after the request strobe.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_wait_cnt <= '0;
            r_last_rd  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                ST_WR_REQ: begin
                    r_last_rd <= 1'b0;
                end
                ST_RD_REQ: begin
                    r_wait_cnt <= 4'(ReadLatency);
                    r_last_rd  <= 1'b1;
                end
                ST_RD_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt == 4'd1) begin
                        r_rdata <= regRData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sda_axi_lite_reg_bridge.sv
// Randomized bench for the AXI-Lite register bridge: register-file reference model,
// register-bus scoreboard and responder, one task per scenario.
module tb_sda_axi_lite_reg_bridge;

    localparam int RAW   = 12;
    localparam int AAW   = 16;
    localparam int LAT   = 1;
    localparam int REC_W = 1 + RAW + 36;
    localparam int TMO   = 200;

    logic           clk = 1'b0;
    logic           srst;
    logic           s_awvalid, s_awready;
    logic [AAW-1:0] s_awaddr;
    logic           s_wvalid, s_wready;
    logic [31:0]    s_wdata;
    logic [3:0]     s_wstrb;
    logic           s_bvalid, s_bready;
    logic [1:0]     s_bresp;
    logic           s_arvalid, s_arready;
    logic [AAW-1:0] s_araddr;
    logic           s_rvalid, s_rready;
    logic [31:0]    s_rdata;
    logic [1:0]     s_rresp;
    logic           regReq, regWriteEn;
    logic [RAW-1:0] regAddr;
    logic [31:0]    regWData;
    logic [3:0]     regWStrb;
    logic [31:0]    regRData;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_req_cyc = 0;

    logic [REC_W-1:0] exp_q[$];
    logic [31:0]      ref_mem[4096];
    logic [31:0]      periph_mem[4096];
    logic             ref_last_rd;
    logic             prev_req = 1'b0;
    int               rd_cnt = 0;
    logic [31:0]      rd_val = '0;
    logic [REC_W-1:0] mon_got, mon_exp, mon_mask;

    sda_axi_lite_reg_bridge #(
        .RegAddrWidth(RAW),
        .AxiAddrWidth(AAW),
        .ReadLatency (LAT)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_bresp   (s_bresp),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .regReq    (regReq),
        .regWriteEn(regWriteEn),
        .regAddr   (regAddr),
        .regWData  (regWData),
        .regWStrb  (regWStrb),
        .regRData  (regRData)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic void model_write(input logic [AAW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int w;
        w = (int'(a) / 4) % 4096;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        end
        exp_q.push_back({1'b1, 12'(w), d, s});
        ref_last_rd = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [AAW-1:0] a);
        int w;
        w = (int'(a) / 4) % 4096;
        exp_q.push_back({1'b0, 12'(w), 36'h0});
        ref_last_rd = 1'b1;
        return ref_mem[w];
    endfunction

    // ---------------- register-bus scoreboard and responder ----------------
    always @(negedge clk) begin
        n_checks++;
        if (regReq && prev_req) begin
            n_errors++;
            $display("FAIL req_spacing: regReq high on consecutive cycles at cycle %0d, required a low cycle between", cyc);
        end
        if (!regReq) begin
            n_checks++;
            if ({regWriteEn, regAddr, regWData, regWStrb} !== '0) begin
                n_errors++;
                $display("FAIL idle_bus: got we=%0b addr=%0h wdata=%h strb=%h, required all zero", regWriteEn, regAddr, regWData, regWStrb);
            end
        end else begin
            mon_got = {regWriteEn, regAddr, regWData, regWStrb};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_req: got %h, required no request", mon_got);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_mask = mon_exp[REC_W-1] ? '1 : {{(RAW + 1){1'b1}}, 36'h0};
                if ((mon_got & mon_mask) !== (mon_exp & mon_mask)) begin
                    n_errors++;
                    $display("FAIL req_record: got %h, required %h", mon_got & mon_mask, mon_exp & mon_mask);
                end
            end
            last_req_cyc = cyc;
            if (regWriteEn) begin
                for (int b = 0; b < 4; b++) begin
                    if (regWStrb[b]) periph_mem[regAddr][8*b +: 8] = regWData[8*b +: 8];
                end
            end
        end
        prev_req = regReq;
        // Read data is valid only during the sampling cycle; junk otherwise.
        if (rd_cnt != 0) begin
            rd_cnt--;
            regRData = (rd_cnt == 0) ? rd_val : $urandom;
        end else begin
            regRData = $urandom;
        end
        if (regReq && !regWriteEn) begin
            rd_cnt = LAT;
            rd_val = periph_mem[regAddr];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_aw(input logic [AAW-1:0] a);
        bit ok = 0;
        s_awvalid = 1'b1;
        s_awaddr  = a;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clk);
            ok = s_awready;
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL aw_timeout: awready got 0 for %0d cycles, required 1", TMO);
        end
        @(posedge clk);
        #1;
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        s_wvalid = 1'b1;
        s_wdata  = d;
        s_wstrb  = s;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clk);
            ok = s_wready;
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL w_timeout: wready got 0 for %0d cycles, required 1", TMO);
        end
        @(posedge clk);
        #1;
        s_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [AAW-1:0] a);
        bit ok = 0;
        s_arvalid = 1'b1;
        s_araddr  = a;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clk);
            ok = s_arready;
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL ar_timeout: arready got 0 for %0d cycles, required 1", TMO);
        end
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
    endtask

    // Waits for B, holds bready low for 'hold' cycles, then completes the handshake.
    task automatic wait_b(input int hold, output logic [1:0] resp, output int lat, output bit stable);
        bit ok = 0;
        resp = 2'b11; lat = -1; stable = 1;
        s_bready = 1'b0;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clk);
            ok = s_bvalid;
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL b_timeout: bvalid got 0 for %0d cycles, required 1", TMO);
        end else begin
            resp = s_bresp;
            lat  = cyc - last_req_cyc;
            repeat (hold) begin
                @(negedge clk);
                if (!s_bvalid) stable = 0;
            end
            s_bready = 1'b1;
            @(posedge clk);
            #1;
            s_bready = 1'b0;
        end
    endtask

    task automatic wait_r(input int hold, output logic [31:0] data, output logic [1:0] resp, output int lat, output bit stable);
        bit ok = 0;
        data = '0; resp = 2'b11; lat = -1; stable = 1;
        s_rready = 1'b0;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clk);
            ok = s_rvalid;
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL r_timeout: rvalid got 0 for %0d cycles, required 1", TMO);
        end else begin
            data = s_rdata;
            resp = s_rresp;
            lat  = cyc - last_req_cyc;
            repeat (hold) begin
                @(negedge clk);
                if (!s_rvalid || s_rdata !== data) stable = 0;
            end
            s_rready = 1'b1;
            @(posedge clk);
            #1;
            s_rready = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        srst = 1'b1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        ref_last_rd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_readys: got %b, required 000", {s_awready, s_wready, s_arready});
        end
        n_checks++;
        if ({s_bvalid, s_rvalid, s_rdata, s_bresp, s_rresp} !== '0) begin
            n_errors++;
            $display("FAIL reset_resp: got bvalid=%0b rvalid=%0b rdata=%h bresp=%0d rresp=%0d, required all zero", s_bvalid, s_rvalid, s_rdata, s_bresp, s_rresp);
        end
        @(posedge clk);
        #1;
        srst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            n_errors++;
            $display("FAIL reset_release_readys: got %b, required 111", {s_awready, s_wready, s_arready});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_basic();
        logic [1:0] resp; int lat; bit st;
        model_write(16'h0100, 32'hDEADBEEF, 4'hF);
        fork
            send_aw(16'h0100);
            send_w(32'hDEADBEEF, 4'hF);
        join
        wait_b(0, resp, lat, st);
        n_checks++;
        if (resp !== 2'b00 || lat != 1) begin
            n_errors++;
            $display("FAIL write_basic_b: got bresp=%0d latency=%0d, required 0 and 1", resp, lat);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL write_basic_req: got %0d requests outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_read_basic();
        logic [1:0] resp; int lat; bit st; logic [31:0] d, e;
        model_write(16'h0104, 32'h12345678, 4'hF);
        fork
            send_aw(16'h0104);
            send_w(32'h12345678, 4'hF);
        join
        wait_b(0, resp, lat, st);
        e = model_read(16'h0104);
        send_ar(16'h0104);
        wait_r(0, d, resp, lat, st);
        n_checks++;
        if (d !== e || resp !== 2'b00) begin
            n_errors++;
            $display("FAIL read_basic_data: got rdata=%h rresp=%0d, required %h and 0", d, resp, e);
        end
        n_checks++;
        if (lat != LAT + 1) begin
            n_errors++;
            $display("FAIL read_basic_latency: got %0d, required %0d", lat, LAT + 1);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL read_basic_req: got %0d requests outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] bresp, rresp; int blat, rlat; bit bst, rst_; logic [31:0] d, e, wd;
        logic [AAW-1:0] a;
        for (int r = 0; r < 2; r++) begin
            a  = AAW'($urandom_range(0, 63) * 4);
            wd = $urandom;
            if (ref_last_rd) begin
                model_write(a, wd, 4'hF);
                e = model_read(a);
            end else begin
                e = model_read(a);
                model_write(a, wd, 4'hF);
            end
            fork
                send_aw(a);
                send_w(wd, 4'hF);
                send_ar(a);
            join
            fork
                wait_b(0, bresp, blat, bst);
                wait_r(0, d, rresp, rlat, rst_);
            join
            n_checks++;
            if (d !== e || rresp !== 2'b00 || bresp !== 2'b00) begin
                n_errors++;
                $display("FAIL arb_round%0d: got rdata=%h rresp=%0d bresp=%0d, required %h 0 0", r, d, rresp, bresp, e);
            end
            n_checks++;
            if (exp_q.size() != 0) begin
                n_errors++;
                $display("FAIL arb_round%0d_req: got %0d requests outstanding, required 0", r, exp_q.size());
            end
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; int lat; bit st; logic [31:0] d;
        d = $urandom;
        model_write(16'h0108, d, 4'h3);
        send_w(d, 4'h3);
        repeat (3) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (s_wready !== 1'b0 || exp_q.size() != 1) begin
                n_errors++;
                $display("FAIL w_early_hold: got wready=%0b pending=%0d, required 0 and 1", s_wready, exp_q.size());
            end
        end
        send_aw(16'h0108);
        wait_b(0, resp, lat, st);
        n_checks++;
        if (resp !== 2'b00 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL w_early_done: got bresp=%0d pending=%0d, required 0 and 0", resp, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; int lat; bit st, seen; logic [31:0] d, e1, e2;
        logic [AAW-1:0] a1, a2;
        a1 = AAW'($urandom_range(0, 4095) * 4);
        a2 = AAW'($urandom_range(0, 4095) * 4);
        e1 = model_read(a1);
        e2 = model_read(a2);
        send_ar(a1);
        fork
            wait_r(5, d, resp, lat, st);
            begin
                seen = 0;
                for (int i = 0; i < TMO && !seen; i++) begin
                    @(negedge clk);
                    seen = s_rvalid;
                end
                n_checks++;
                if (s_arready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bp_arready: got %0b while R stalled, required 1", s_arready);
                end
                @(posedge clk);
                #1;
                send_ar(a2);
            end
        join
        n_checks++;
        if (d !== e1 || !st) begin
            n_errors++;
            $display("FAIL bp_first_read: got rdata=%h stable=%0b, required %h and 1", d, st, e1);
        end
        n_checks++;
        if (exp_q.size() != 1) begin
            n_errors++;
            $display("FAIL bp_second_early: got %0d requests pending at R handshake, required 1", exp_q.size());
        end
        wait_r(0, d, resp, lat, st);
        n_checks++;
        if (d !== e2 || resp !== 2'b00 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL bp_second_read: got rdata=%h rresp=%0d pending=%0d, required %h 0 0", d, resp, exp_q.size(), e2);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; int lat; bit st, seen; logic [31:0] d;
        logic [AAW-1:0] a;
        a = AAW'($urandom_range(0, 4095) * 4);
        d = $urandom;
        send_w(d, 4'hF);
        void'(model_read(a));
        send_ar(a);
        seen = 0;
        for (int i = 0; i < TMO && !seen; i++) begin
            @(negedge clk);
            seen = regReq;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL rstmid_req: regReq got 0 for %0d cycles, required 1", TMO);
        end
        @(posedge clk);
        #1;
        srst = 1'b1;
        ref_last_rd = 1'b0;
        #1;
        n_checks++;
        if ({regReq, regWriteEn, regAddr, regWData, regWStrb, s_rvalid, s_arready} !== '0) begin
            n_errors++;
            $display("FAIL rstmid_outputs: got req=%0b addr=%0h rvalid=%0b arready=%0b, required all zero", regReq, regAddr, s_rvalid, s_arready);
        end
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if (s_rvalid !== 1'b0 || s_bvalid !== 1'b0) begin
                n_errors++;
                $display("FAIL rstmid_no_resp: got rvalid=%0b bvalid=%0b, required 0 0", s_rvalid, s_bvalid);
            end
        end
        @(posedge clk);
        #1;
        // The W beat taken before reset must be gone: a lone AW issues nothing.
        send_aw(a);
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (s_bvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_discard: got bvalid=%0b with only AW held, required 0", s_bvalid);
        end
        d = $urandom;
        model_write(a, d, 4'hF);
        send_w(d, 4'hF);
        wait_b(0, resp, lat, st);
        n_checks++;
        if (resp !== 2'b00 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rstmid_recover: got bresp=%0d pending=%0d, required 0 and 0", resp, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [1:0] resp; int lat, hold, d1, d2; bit st; logic [31:0] d, e;
        logic [3:0] s; logic [AAW-1:0] a;
        for (int n = 0; n < 60; n++) begin
            a    = AAW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3) + $urandom_range(0, 15) * 16384);
            hold = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                d  = $urandom;
                s  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                d1 = $urandom_range(0, 3);
                d2 = $urandom_range(0, 3);
                model_write(a, d, s);
                fork
                    begin repeat (d1) begin @(posedge clk); #1; end send_aw(a); end
                    begin repeat (d2) begin @(posedge clk); #1; end send_w(d, s); end
                join
                wait_b(hold, resp, lat, st);
                n_checks++;
                if (resp !== 2'b00 || !st || lat < 1) begin
                    n_errors++;
                    $display("FAIL rand_write%0d: got bresp=%0d stable=%0b latency=%0d, required 0 1 >=1", n, resp, st, lat);
                end
            end else begin
                e = model_read(a);
                send_ar(a);
                wait_r(hold, d, resp, lat, st);
                n_checks++;
                if (d !== e || resp !== 2'b00 || !st || lat != LAT + 1) begin
                    n_errors++;
                    $display("FAIL rand_read%0d: got rdata=%h rresp=%0d stable=%0b latency=%0d, required %h 0 1 %0d", n, d, resp, st, lat, e, LAT + 1);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rand_drain: got %0d requests outstanding, required 0", exp_q.size());
        end
        for (int w = 0; w < 16; w++) begin
            n_checks++;
            if (periph_mem[w] !== ref_mem[w]) begin
                n_errors++;
                $display("FAIL rand_regfile[%0d]: got %h, required %h", w, periph_mem[w], ref_mem[w]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        regRData = '0;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i]    = '0;
            periph_mem[i] = '0;
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_arbitration();
        test_w_before_aw();
        test_backpressure();
        test_reset_mid();
        test_random();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
